ldpc_bitflip_decoder: RTL and testbench
=======================================

Name: ldpc_bitflip_decoder

Overview:
Iterative hard-decision bit-flipping decoder for the team's (15-bit) cyclic LDPC code. It sits directly downstream of the syndrome detector. It accepts a received 15-bit word and recomputes the syndrome every cycle from the same parity-check matrix. Each iteration it flips the bits implicated by the most unsatisfied checks, until the syndrome is zero or an iteration cap is reached. The corrected word, a success flag, the residual syndrome and the iteration count are then presented on a valid/ready output.

Parameters:
MAX_ITER, 8, maximum flip iterations per word (0 allowed: detect-only)
ITER_W, 4, width of iteration counter/output; must hold MAX_ITER (elaboration error otherwise)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  decoder can accept a word (high only in IDLE)
in_word  input  15  received hard-decision word, bit j = code bit j
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
out_word  output  15  decoded word
out_ok  output  1  1 = out_syndrome is all-zero
out_syndrome  output  15  syndrome of out_word
out_iters  output  ITER_W  number of flip iterations performed

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Check i (i=0..14) covers bits {i, i+8, i+9, i+11} mod 15; s[i] = XOR of those bits.
- Bit j is in checks {j, j+4, j+6, j+7} mod 15 (column weight 4). Any two bits share at most one check.
- Syndrome and per-bit unsatisfied counts (0..4, 3 bits each) are combinational from the internal word register w.
- The flip mask is every bit whose count equals the maximum count over all 15 bits. Ties flip all tied bits.
- States: IDLE, ITER, DONE.
- IDLE: in_ready=1. On in_valid: w<=in_word, iter<=0, go to ITER.
- ITER: in_ready=0, out_valid=0.
  - If syndrome(w)==0: go to DONE, ok<=1.
  - Else if iter==MAX_ITER: go to DONE, ok<=0.
  - Else: w<=w^flip_mask, iter<=iter+1, stay in ITER.
- DONE: out_valid=1. out_word, out_ok, out_syndrome and out_iters are registered and stable. On out_ready: go to IDLE. Otherwise hold all outputs indefinitely.
- A new word is accepted no earlier than the cycle after the DONE handshake. There is no overlap and no bypass.
- Latency from the in handshake at cycle T to out_valid is T+2+k, where k = iterations used. A clean word gives T+2.
- Throughput: one word per (3+k) cycles when out_ready is held high.
- Syndrome nonzero implies max count >=1, so the flip mask is never empty.
- in_word is sampled only on the accepting cycle. Changes on in_word outside that cycle are ignored.
- Reset values: state=IDLE, in_ready=1 (after reset deasserts), out_valid=0, out_word=0, out_ok=0, out_syndrome=0, out_iters=0, w=0, iter=0.
- rst asserted in any state, including mid-ITER or mid-DONE, returns to the reset values on the next edge. The in-flight word is discarded and no output is produced for it.

Test Plan:
- Clean words: in_word=0x0000, then 0x7FFF (all-ones is a codeword, every row weight 4). Required: out_word equals input, ok=1, syndrome=0, iters=0, out_valid at T+2.
- Single errors: in_word=0x0001 (bit 0; unsatisfied checks 0,4,6,7). Required: out_word=0x0000, ok=1, iters=1, out_valid at T+3. Sweep all 15 single-bit errors on 0x0000 and on 0x7FFF: every case corrected with iters=1.
- Double error: in_word=0x0003 (unsatisfied checks {0,1,4,5,6,8}; bits 0,1 count 3, others at most 2). Required: out_word=0x0000, ok=1, iters=1.
- Iteration cap: MAX_ITER=0, in_word=0x0001. Required: out_word=0x0001, ok=0, out_syndrome=0x00D1 (bits 0,4,6,7), iters=0, out_valid at T+2.
- Backpressure: during DONE, hold out_ready=0 for 5 cycles while toggling in_valid/in_word. Required: outputs stable, in_ready=0, second word accepted only the cycle after out_ready=1.
- Reset mid-ITER: apply rst for 1 cycle at T+1 after accepting 0x0003. Required: out_valid never asserts for that word, all outputs return to 0, in_ready=1 next cycle, next word decodes normally.

Source files
------------

// File: rtl/ldpc_bitflip_decoder_if.sv
// Handshake bundle for the bit-flip decoder.
//   in_valid/in_ready/in_word       : received word, accepted on valid & ready
//   out_valid/out_ready             : result handshake
//   out_word/out_ok/out_syndrome    : decoded word, zero-syndrome flag, residual syndrome
//   out_iters                       : flip iterations used for this word
// slave modport is the decoder side; master modport is the producer/consumer side.
interface ldpc_bitflip_decoder_if #(
  parameter int ITER_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [14:0]       in_word;
  logic              out_valid;
  logic              out_ready;
  logic [14:0]       out_word;
  logic              out_ok;
  logic [14:0]       out_syndrome;
  logic [ITER_W-1:0] out_iters;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_ok, out_syndrome, out_iters
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_ok, out_syndrome, out_iters
  );
endinterface

// File: rtl/ldpc_bitflip_decoder.sv
// Hard-decision bit-flipping decoder for the 15-bit cyclic LDPC code.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ldpc_bitflip_decoder_if.slave (input word handshake, result handshake)
//
// state | meaning
// IDLE  | waiting for an input word, in_ready high
// ITER  | recompute syndrome each cycle, flip worst bits until clean or capped
// DONE  | registered result presented with out_valid until out_ready
module ldpc_bitflip_decoder #(
  parameter int MAX_ITER = 8,
  parameter int ITER_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ldpc_bitflip_decoder_if.slave bus
);

  if (MAX_ITER < 0 || MAX_ITER > (2 ** ITER_W) - 1) begin : g_bad_iter_w
    $error("ldpc_bitflip_decoder: MAX_ITER does not fit in ITER_W bits");
  end

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t            state, state_d;
  logic [14:0]       w;
  logic [ITER_W-1:0] iter;
  logic [14:0]       syn;
  logic [2:0]        cnt [15];
  logic [2:0]        max_cnt;
  logic [14:0]       flip;
  logic              at_cap;

  // Check i covers bits {i, i+8, i+9, i+11} mod 15.
  always_comb begin
    syn = '0;
    for (int i = 0; i < 15; i++) begin
      syn[i] = w[i] ^ w[(i + 8) % 15] ^ w[(i + 9) % 15] ^ w[(i + 11) % 15];
    end
  end

  // Bit j sits in checks {j, j+4, j+6, j+7} mod 15; count its unsatisfied checks.
  always_comb begin
    for (int j = 0; j < 15; j++) begin
      cnt[j] = {2'b00, syn[j]} + {2'b00, syn[(j + 4) % 15]}
             + {2'b00, syn[(j + 6) % 15]} + {2'b00, syn[(j + 7) % 15]};
    end
  end

  always_comb begin
    max_cnt = '0;
    for (int j = 0; j < 15; j++) begin
      if (cnt[j] > max_cnt) max_cnt = cnt[j];
    end
  end

  // All bits tied at the maximum flip together; an all-zero max means nothing to flip.
  always_comb begin
    flip = '0;
    for (int j = 0; j < 15; j++) begin
      flip[j] = (max_cnt != 3'd0) && (cnt[j] == max_cnt);
    end
  end

  assign at_cap = (iter == ITER_W'(MAX_ITER));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.in_valid) state_d = ITER;
      ITER:    if (syn == '0 || at_cap) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w                <= '0;
      iter             <= '0;
      bus.out_word     <= '0;
      bus.out_ok       <= 1'b0;
      bus.out_syndrome <= '0;
      bus.out_iters    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            w    <= bus.in_word;
            iter <= '0;
          end
        end
        ITER: begin
          if (syn == '0 || at_cap) begin
            bus.out_word     <= w;
            bus.out_ok       <= (syn == '0);
            bus.out_syndrome <= syn;
            bus.out_iters    <= iter;
          end else begin
            w    <= w ^ flip;
            iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

endmodule

// File: tb/tb_ldpc_bitflip_decoder.sv
module tb_ldpc_bitflip_decoder;

  typedef struct {
    logic [14:0] in_word;
    logic [14:0] exp_word;
    logic        exp_ok;
    logic [14:0] exp_syn;
    logic [3:0]  exp_iters;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs [$];
  vec_t sb   [$];

  always #5 clk = ~clk;

  ldpc_bitflip_decoder_if #(.ITER_W(4)) bus ();
  ldpc_bitflip_decoder_if #(.ITER_W(4)) bus0 ();

  ldpc_bitflip_decoder #(.MAX_ITER(8), .ITER_W(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  ldpc_bitflip_decoder #(.MAX_ITER(0), .ITER_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input vec_t v, input bit push);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_word  = v.in_word;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    if (push) sb.push_back(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_word  = ~v.in_word;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (n >= 60) chk("out_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_out(input int n);
    vec_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("word[%h]", e.in_word), {17'd0, bus.out_word}, {17'd0, e.exp_word});
    chk($sformatf("ok[%h]", e.in_word), {31'd0, bus.out_ok}, {31'd0, e.exp_ok});
    chk($sformatf("syn[%h]", e.in_word), {17'd0, bus.out_syndrome}, {17'd0, e.exp_syn});
    chk($sformatf("iters[%h]", e.in_word), {28'd0, bus.out_iters}, {28'd0, e.exp_iters});
    chk($sformatf("latency[%h]", e.in_word), n, 32'(e.exp_iters) + 32'd1);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    chk("in_ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
    chk("out_valid_after_hs", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic collect();
    int n;
    wait_valid(n);
    if (n < 60) check_out(n);
    else if (sb.size() > 0) void'(sb.pop_front());
    release_out();
  endtask

  function automatic vec_t mk(input logic [14:0] iw, input logic [14:0] ew,
                              input logic ok, input logic [14:0] s, input logic [3:0] it);
    vec_t v;
    v.in_word = iw; v.exp_word = ew; v.exp_ok = ok; v.exp_syn = s; v.exp_iters = it;
    return v;
  endfunction

  initial begin
    vec_t cap [2];
    vec_t v;
    int   n;
    logic [14:0] one;

    vecs.push_back(mk(15'h0000, 15'h0000, 1'b1, 15'h0, 4'd0));
    vecs.push_back(mk(15'h7FFF, 15'h7FFF, 1'b1, 15'h0, 4'd0));
    vecs.push_back(mk(15'h0001, 15'h0000, 1'b1, 15'h0, 4'd1));
    vecs.push_back(mk(15'h0003, 15'h0000, 1'b1, 15'h0, 4'd1));
    for (int j = 0; j < 15; j++) begin
      one = 15'h0001 << j;
      vecs.push_back(mk(one, 15'h0000, 1'b1, 15'h0, 4'd1));
      vecs.push_back(mk(15'h7FFF ^ one, 15'h7FFF, 1'b1, 15'h0, 4'd1));
    end
    cap[0] = mk(15'h0001, 15'h0001, 1'b0, 15'h00D1, 4'd0);
    cap[1] = mk(15'h7FFF, 15'h7FFF, 1'b1, 15'h0000, 4'd0);

    bus.in_valid = 1'b0;  bus.in_word = '0;  bus.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_word = '0; bus0.out_ready = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_word", {17'd0, bus.out_word}, 32'd0);
    chk("rst_out_ok", {31'd0, bus.out_ok}, 32'd0);
    chk("rst_out_syn", {17'd0, bus.out_syndrome}, 32'd0);
    chk("rst_out_iters", {28'd0, bus.out_iters}, 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i], 1'b1);
      collect();
    end

    // Backpressure: hold result while input side is noisy.
    send(mk(15'h0001, 15'h0000, 1'b1, 15'h0, 4'd1), 1'b1);
    wait_valid(n);
    check_out(n);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_word  = 15'($urandom);
      @(posedge clk); @(negedge clk);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_word", {17'd0, bus.out_word}, 32'd0);
      chk("bp_out_iters", {28'd0, bus.out_iters}, 32'd1);
      chk("bp_out_ok", {31'd0, bus.out_ok}, 32'd1);
    end
    bus.in_valid  = 1'b1;
    bus.in_word   = 15'h7FFF;
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_in_ready_next", {31'd0, bus.in_ready}, 32'd1);
    send(mk(15'h7FFF, 15'h7FFF, 1'b1, 15'h0, 4'd0), 1'b1);
    collect();

    // Reset during ITER discards the word.
    send(mk(15'h0003, 15'h0000, 1'b1, 15'h0, 4'd1), 1'b0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_out_word", {17'd0, bus.out_word}, 32'd0);
    chk("mid_rst_out_ok", {31'd0, bus.out_ok}, 32'd0);
    chk("mid_rst_out_syn", {17'd0, bus.out_syndrome}, 32'd0);
    chk("mid_rst_out_iters", {28'd0, bus.out_iters}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk("mid_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    send(mk(15'h0001, 15'h0000, 1'b1, 15'h0, 4'd1), 1'b1);
    collect();

    // Detect-only instance (MAX_ITER = 0).
    for (int k = 0; k < 2; k++) begin
      v = cap[k];
      chk("cap_in_ready", {31'd0, bus0.in_ready}, 32'd1);
      bus0.in_valid = 1'b1;
      bus0.in_word  = v.in_word;
      @(posedge clk); @(negedge clk);
      bus0.in_valid = 1'b0;
      n = 0;
      while (bus0.out_valid !== 1'b1 && n < 60) begin
        @(posedge clk); @(negedge clk); n++;
      end
      chk($sformatf("cap_latency[%0d]", k), n, 32'd1);
      chk($sformatf("cap_word[%0d]", k), {17'd0, bus0.out_word}, {17'd0, v.exp_word});
      chk($sformatf("cap_ok[%0d]", k), {31'd0, bus0.out_ok}, {31'd0, v.exp_ok});
      chk($sformatf("cap_syn[%0d]", k), {17'd0, bus0.out_syndrome}, {17'd0, v.exp_syn});
      chk($sformatf("cap_iters[%0d]", k), {28'd0, bus0.out_iters}, {28'd0, v.exp_iters});
      bus0.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus0.out_ready = 1'b0;
    end

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
